// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// Cycles through NUM_DIGITS digits, handing each digit's nibble to a shared
// external nibble-to-segment converter. Each slot has a blanked dead-time and
// then a lit SHOW period. New display values are staged in a shadow register
// and committed only at frame boundaries, so no frame mixes old and new digits.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,      // 2..8 multiplexed digits
    parameter int REFRESH_DIV = 50000,  // SHOW cycles per digit slot (>= 2)
    parameter int BLANK_CYC   = 16      // dead-time cycles before each SHOW (>= 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_load_data,
    input  logic                    i_blank_lz,
    output logic                    o_busy,
    output logic                    o_upd_done,
    output logic [3:0]              o_cur_nibble,
    input  logic [6:0]              i_seg_in,
    output logic [6:0]              o_seg_out,
    output logic [NUM_DIGITS-1:0]   o_an
);

    // One counter serves both phases, so size it for the longer one.
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Scan FSM state
    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;

    // Display / load path
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_busy;
    logic                    r_upd_done;

    // Pin-facing registers
    logic [3:0]              r_cur_nibble;
    logic [6:0]              r_seg_out;
    logic [NUM_DIGITS-1:0]   r_an;

    // Decoded helpers
    logic                    w_blank_last;
    logic                    w_show_last;
    logic                    w_idx_wrap;
    logic [IDX_W-1:0]        w_idx_inc;
    logic                    w_commit;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic                    w_lz_run [1:NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [NUM_DIGITS-1:0]   w_an_sel;

    assign w_blank_last = (r_state == ST_BLANK) && (r_cnt == CNT_W'(BLANK_CYC - 1));
    assign w_show_last  = (r_state == ST_SHOW)  && (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_idx_wrap   = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_idx_inc    = w_idx_wrap ? '0 : r_idx + 1'b1;

    // Commit happens exactly when the last digit's SHOW ends, i.e. on the
    // frame boundary, and only if a staged value is waiting.
    assign w_commit     = w_show_last && w_idx_wrap && r_busy;

    // Top of the leading-zero chain: nothing sits above the highest digit.
    assign w_lz_run[NUM_DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi]    = r_display[4*gi +: 4];
            assign w_an_sel[gi] = (r_idx == IDX_W'(gi));

            if (gi == 0) begin : g_lsd
                // The least significant digit always shows, so a value of
                // zero still displays "0"; only the F code blanks it.
                assign w_supp[gi] = (w_nib[gi] == 4'hF);
            end else begin : g_upper
                // w_lz_run[k]: nibbles k..NUM_DIGITS-1 are all zero.
                assign w_lz_run[gi] = (w_nib[gi] == 4'h0) & w_lz_run[gi+1];
                assign w_supp[gi]   = (w_nib[gi] == 4'hF) | (i_blank_lz & w_lz_run[gi]);
            end
        end
    endgenerate

    // FSM state, phase counter and digit index registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state logic: BLANK for BLANK_CYC cycles, SHOW for REFRESH_DIV,
    // then advance to the next digit.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        if (w_blank_last) begin
            w_state_next = ST_SHOW;
            w_cnt_next   = '0;
        end else if (w_show_last) begin
            w_state_next = ST_BLANK;
            w_cnt_next   = '0;
            w_idx_next   = w_idx_inc;
        end
    end

    // Shadow capture, frame-boundary commit, busy flag and update pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_display  <= '0;
            r_shadow   <= '0;
            r_busy     <= 1'b0;
            r_upd_done <= 1'b0;
        end else begin
            r_upd_done <= w_commit;
            if (w_commit) begin
                // Uses the shadow as it was before any same-cycle load.
                r_display <= r_shadow;
            end
            if (i_load) begin
                // A load coinciding with a commit stays pending for the next frame.
                r_shadow <= i_load_data;
                r_busy   <= 1'b1;
            end else if (w_commit) begin
                r_busy   <= 1'b0;
            end
        end
    end

    // Present the upcoming digit's nibble to the converter on entry to BLANK,
    // giving the external decode the whole dead-time to settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_nibble <= 4'h0;
        end else if (w_show_last) begin
            // On a commit the display register is not yet updated, so digit 0
            // of the new value comes straight from the shadow.
            r_cur_nibble <= w_commit ? r_shadow[3:0] : w_nib[w_idx_inc];
        end
    end

    // Segment and anode drive: change only at slot phase transitions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an      <= '1;
            r_seg_out <= SEG_OFF;
        end else if (w_blank_last) begin
            // blank_lz is sampled here, once per slot.
            if (w_supp[r_idx]) begin
                r_an      <= '1;
                r_seg_out <= SEG_OFF;
            end else begin
                r_an      <= ~w_an_sel;
                r_seg_out <= i_seg_in;
            end
        end else if (w_show_last) begin
            r_an      <= '1;
            r_seg_out <= SEG_OFF;
        end
    end

    assign o_busy       = r_busy;
    assign o_upd_done   = r_upd_done;
    assign o_cur_nibble = r_cur_nibble;
    assign o_seg_out    = r_seg_out;
    assign o_an         = r_an;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2).
// The stimulus process queues the per-cycle expected pin state of each frame
// from hand-written digit codes, then drives loads/resets at fixed cycles.
// A separate monitor pops one expectation per cycle and compares.
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int SLOT = BC + RD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] load_data;
    logic        blank_lz;
    logic        busy;
    logic        upd_done;
    logic [3:0]  cur_nibble;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load       (load),
        .i_load_data  (load_data),
        .i_blank_lz   (blank_lz),
        .o_busy       (busy),
        .o_upd_done   (upd_done),
        .o_cur_nibble (cur_nibble),
        .i_seg_in     (seg_in),
        .o_seg_out    (seg_out),
        .o_an         (an)
    );

    // External hex-to-7-segment converter, active-low gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb seg_in = hex7(cur_nibble);

    typedef struct packed {
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_busy;
        logic       e_upd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    // Hand-chosen segment codes
    localparam logic [6:0] S0   = 7'h40;
    localparam logic [6:0] S1   = 7'h79;
    localparam logic [6:0] S2   = 7'h24;
    localparam logic [6:0] S3   = 7'h30;
    localparam logic [6:0] S4   = 7'h19;
    localparam logic [6:0] S7   = 7'h78;
    localparam logic [6:0] S8   = 7'h00;
    localparam logic [6:0] SOFF = 7'h7F;

    task automatic push_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.e_an = 4'hF; e.e_seg = SOFF; e.e_busy = 1'b0; e.e_upd = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Expand one frame: per slot BC blanked cycles then RD lit cycles
    // (or blanked if that digit is suppressed).
    task automatic push_frame(input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3,
                              input logic [3:0] supp, input logic upd,
                              input logic busy0, input int set_at, input int len);
        logic [6:0] codes [4];
        exp_t e;
        int slot;
        int ph;
        codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
        for (int i = 0; i < len; i++) begin
            slot = i / SLOT;
            ph   = i % SLOT;
            e.e_an  = 4'hF;
            e.e_seg = SOFF;
            if (ph >= BC && !supp[slot]) begin
                e.e_an  = ~(4'b0001 << slot);
                e.e_seg = codes[slot];
            end
            e.e_busy = busy0 | ((set_at >= 0) && (i >= set_at));
            e.e_upd  = upd && (i == 0);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one expectation per cycle, sampled 1 time unit after negedge.
    initial begin
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL underrun cyc=%0d got=empty_queue want=expectation", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (an !== e.e_an) begin
                        errors++;
                        $display("FAIL an cyc=%0d got=%b want=%b", cyc, an, e.e_an);
                    end
                    checks++;
                    if (seg_out !== e.e_seg) begin
                        errors++;
                        $display("FAIL seg_out cyc=%0d got=%b want=%b", cyc, seg_out, e.e_seg);
                    end
                    checks++;
                    if (busy !== e.e_busy) begin
                        errors++;
                        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, e.e_busy);
                    end
                    checks++;
                    if (upd_done !== e.e_upd) begin
                        errors++;
                        $display("FAIL upd_done cyc=%0d got=%b want=%b", cyc, upd_done, e.e_upd);
                    end
                end
                cyc++;
            end
        end
    end

    task automatic do_load(input int t, input logic [15:0] d);
        load      = 1'b1;
        load_data = d;
        $display("t=%0d load data=%h", t, d);
    endtask

    // Stimulus: queue expectations, then drive events at fixed frame times
    // (t = 0 is the cycle in which reset is released).
    initial begin
        int t;
        rst_n     = 1'b0;
        load      = 1'b0;
        load_data = 16'h0;
        blank_lz  = 1'b0;

        push_reset(3);                                                   // held in reset
        push_frame(S0, S0, S0, S0, 4'b0000, 1'b0, 1'b0, 16, 40);         // idle zeros, load 1234 mid-frame
        push_frame(S4, S3, S2, S1, 4'b0000, 1'b1, 1'b0, 11, 40);         // 1234 committed
        push_frame(S0, S7, SOFF, SOFF, 4'b1100, 1'b1, 1'b0, 11, 40);     // 0070 with blank_lz
        push_frame(S0, SOFF, SOFF, SOFF, 4'b1110, 1'b1, 1'b0, 6, 40);    // 0000 with blank_lz
        push_frame(S1, S2, SOFF, S8, 4'b0100, 1'b1, 1'b0, 6, 40);        // 8F21, F blanks digit 2
        push_frame(S2, S2, S2, S2, 4'b0000, 1'b1, 1'b0, 11, 40);         // 2222 wins over 1111
        push_frame(S3, S3, S3, S3, 4'b0000, 1'b1, 1'b1, -1, 40);         // 3333, 4444 still pending
        push_frame(S4, S4, S4, S4, 4'b0000, 1'b1, 1'b0, 11, 25);         // 4444 until reset mid digit 2
        push_reset(3);                                                   // mid-frame reset
        push_frame(S0, S0, S0, S0, 4'b0000, 1'b0, 1'b0, -1, 40);         // restart, pending load dropped
        push_frame(S0, S0, S0, S0, 4'b0000, 1'b0, 1'b0, -1, 40);         // no late commit
        mon_on = 1'b1;

        for (int a = 0; a < 391; a++) begin
            @(negedge clk);
            t    = a - 3;
            load = 1'b0;
            case (t)
                0:   begin rst_n = 1'b1; $display("t=%0d reset released", t); end
                15:  do_load(t, 16'h1234);
                50:  begin blank_lz = 1'b1; do_load(t, 16'h0070); end
                90:  do_load(t, 16'h0000);
                125: do_load(t, 16'h8F21);
                155: begin blank_lz = 1'b0; $display("t=%0d blank_lz=0", t); end
                165: do_load(t, 16'h1111);
                175: do_load(t, 16'h2222);
                210: do_load(t, 16'h3333);
                239: do_load(t, 16'h4444);
                290: do_load(t, 16'h5555);
                305: begin rst_n = 1'b0; $display("t=%0d reset asserted", t); end
                308: begin rst_n = 1'b1; $display("t=%0d reset released", t); end
                default: ;
            endcase
        end
        #2;
        mon_on = 1'b0;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d want=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS BCD/hex digits onto one shared 7-segment bus and one shared nibble-to-segment converter.
- Each scan slot: presents the digit's nibble to the external converter, blanks all anodes for a dead-time, then drives the registered segments with one anode active.
- New display values enter via a load handshake and commit only at frame boundaries, so a frame never shows mixed old/new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, SHOW cycles per digit slot (>=2).
- BLANK_CYC, 16, dead-time cycles with all anodes off before each SHOW (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  request to capture load_data into shadow register.
- load_data  in  4*NUM_DIGITS  digit nibbles; digit 0 = [3:0] (least significant).
- blank_lz  in  1  1 = suppress leading-zero digits.
- busy  out  1  shadow holds an uncommitted value.
- upd_done  out  1  one-cycle pulse when shadow is committed to the display register.
- cur_nibble  out  4  nibble to the shared converter.
- seg_in  in  7  converter output for cur_nibble, active-low gfedcba, combinational.
- seg_out  out  7  registered segments to pins, active-low.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-high.

Behaviour:
- Reset (async, rst_n=0):
  - an = all 1; seg_out = 7'b1111111; cur_nibble = 0; busy = 0; upd_done = 0.
  - Display and shadow registers = 0; digit index = 0; FSM = BLANK; counter = 0.
  - Reset mid-frame aborts the slot and drops any pending load.
- FSM states: BLANK, SHOW.
  - BLANK: an all 1, seg_out all 1. cur_nibble = display nibble of current index, set on entry. Stay BLANK_CYC cycles. On the last BLANK cycle, capture seg_out <= seg_in, then go to SHOW.
  - SHOW: an[index]=0 unless the digit is suppressed (then an all 1, seg_out all 1). Stay REFRESH_DIV cycles, then index <= index+1 (wraps NUM_DIGITS-1 -> 0), go to BLANK.
- Frame length = NUM_DIGITS*(BLANK_CYC+REFRESH_DIV) cycles.
- Suppression rules:
  - Nibble 4'hF always suppresses that digit.
  - With blank_lz=1, digit k is suppressed if its nibble and all higher-index nibbles are 0.
  - Digit 0 is never suppressed by blank_lz, so value 0 shows "0".
  - Nibbles 10..14 pass to the converter unmodified.
- blank_lz is sampled at each BLANK->SHOW transition.
- Load handshake:
  - load=1 in any cycle: shadow <= load_data; busy <= 1 next cycle.
  - load while busy=1: shadow is overwritten, last write wins; exactly one commit and one upd_done follow.
- Commit:
  - Occurs on the SHOW->BLANK transition out of index NUM_DIGITS-1 when busy=1.
  - Display <= shadow; busy <= 0; upd_done=1 for that single cycle.
  - The first BLANK of digit 0 presents the new nibble.
- Load in the same cycle as commit: commit uses the old shadow; the new data is captured; busy stays 1; the next commit is one frame later.
- seg_out changes only on BLANK->SHOW and SHOW->BLANK transitions, never mid-slot.

Test Plan:
(Parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.)
- Reset then idle:
  - an=4'b1111, seg_out=7'h7F for 2 cycles.
  - Then an=4'b1110 for 8 cycles with seg_out = converter code for 0 (7'b1000000).
  - Full frame = 40 cycles.
- load=1 with load_data=16'h1234 mid-frame:
  - busy=1 next cycle.
  - upd_done pulses exactly once at the end of digit 3 SHOW; busy drops.
  - Next frame shows 4,3,2,1 on an[0..3] with codes 0011001, 0110000, 0100100, 1111001.
- blank_lz=1, data 16'h0070: an[3] and an[2] never go low; digits 1 and 0 show "7" and "0". With data 16'h0000, only digit 0 lights.
- Nibble 4'hF in digit 2: an[2] stays 1 and seg_out=7'h7F during its slot. Slot timing is unchanged.
- Two loads (16'h1111 then 16'h2222) before commit: one upd_done; display = 2222. Load coincident with commit: busy stays 1 and a second commit occurs 40 cycles later.
- rst_n low mid-SHOW of digit 2 with busy=1: outputs immediately return to reset values; busy=0; no upd_done; scan restarts at digit 0 BLANK.
